// File: rtl/sha256_byte_packer_pkg.sv
// sha256_byte_packer_pkg
//   Shared constants and FSM state encoding for the SHA-256 byte packer.
//   BLOCK_WORDS : 32-bit words per 512-bit block
//   LEN_POS     : byte position where the 64-bit length field starts
//   PAD_BYTE    : first padding byte
package sha256_byte_packer_pkg;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned LEN_POS     = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    StLoad  = 3'd0,
    StPad80 = 3'd1,
    StZero  = 3'd2,
    StLenHi = 3'd3,
    StLenLo = 3'd4,
    StWait  = 3'd5
  } state_e;

endpackage

// File: rtl/sha256_byte_packer.sv
// sha256_byte_packer
//   Packs a byte stream big-endian into the 16-word block buffer through per-byte write
//   enables and appends SHA-256 padding (0x80, zero fill, 64-bit bit length). Each finished
//   block is offered to the consumer with blk_valid/blk_ready.
// Ports
//   CLK, rst        : clock, synchronous active-high reset
//   in_byte/in_valid/in_last/in_ready : byte stream, accepted on in_valid & in_ready
//   wr_en/wr_addr/wr_data : registered byte-enable write port to the block buffer
//                           (wr_en[3] = bits 31:24 = byte 0 of the word)
//   blk_valid/blk_last/blk_ready : completed-block handshake; blk_last marks the final block
module sha256_byte_packer
  import sha256_byte_packer_pkg::*;
#(
  parameter int unsigned LEN_W = 13
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [3:0]  wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        blk_valid,
  output logic        blk_last,
  input  logic        blk_ready
);

  state_e           r_state;
  state_e           r_resume;   // state to re-enter once the consumer frees the buffer
  logic             r_last;     // block being offered ends the message
  logic [5:0]       r_pos;
  logic [LEN_W-1:0] r_cnt;
  logic [3:0]       r_wr_en;
  logic [3:0]       r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_blk_valid;
  logic             r_blk_last;

  logic [63:0]      w_bitlen;
  logic [6:0]       w_zero_next;

  always_comb begin
    w_bitlen = '0;
    w_bitlen[LEN_W+2:0] = {r_cnt, 3'b000};
  end

  // Next word boundary after the current position; 7 bits so that 64 is representable.
  assign w_zero_next = {1'b0, r_pos[5:2], 2'b00} + 7'd4;

  assign in_ready  = (r_state == StLoad) && !rst;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= StLoad;
      r_resume    <= StLoad;
      r_last      <= 1'b0;
      r_pos       <= '0;
      r_cnt       <= '0;
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
    end else begin
      r_wr_en     <= 4'b0000;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (in_valid) begin
            r_wr_en   <= 4'b1000 >> r_pos[1:0];
            r_wr_addr <= r_pos[5:2];
            r_wr_data <= {4{in_byte}};
            r_pos     <= r_pos + 6'd1;
            r_cnt     <= r_cnt + 1'b1;
            // A full block always goes to the consumer first; padding of a message whose
            // last byte filled the block then starts in the next block.
            if (r_pos == 6'd63) begin
              r_state  <= StWait;
              r_last   <= 1'b0;
              r_resume <= in_last ? StPad80 : StLoad;
            end else if (in_last) begin
              r_state <= StPad80;
            end
          end
        end
        StPad80: begin
          r_wr_en   <= 4'b1000 >> r_pos[1:0];
          r_wr_addr <= r_pos[5:2];
          r_wr_data <= {4{PAD_BYTE}};
          r_pos     <= r_pos + 6'd1;
          if (r_pos == 6'd63) begin
            r_state  <= StWait;
            r_last   <= 1'b0;
            r_resume <= StZero;
          end else if (r_pos == 6'(LEN_POS - 1)) begin
            r_state <= StLenHi;
          end else begin
            r_state <= StZero;
          end
        end
        StZero: begin
          // Partial word: clear the remaining lanes; aligned: mask is all ones.
          r_wr_en   <= 4'b1111 >> r_pos[1:0];
          r_wr_addr <= r_pos[5:2];
          r_wr_data <= '0;
          r_pos     <= w_zero_next[5:0];
          if (w_zero_next == 7'd64) begin
            r_state  <= StWait;
            r_last   <= 1'b0;
            r_resume <= StZero;
          end else if (w_zero_next == 7'(LEN_POS)) begin
            r_state <= StLenHi;
          end
        end
        StLenHi: begin
          r_wr_en   <= 4'hF;
          r_wr_addr <= 4'(BLOCK_WORDS - 2);
          r_wr_data <= w_bitlen[63:32];
          r_state   <= StLenLo;
        end
        StLenLo: begin
          r_wr_en   <= 4'hF;
          r_wr_addr <= 4'(BLOCK_WORDS - 1);
          r_wr_data <= w_bitlen[31:0];
          r_state   <= StWait;
          r_last    <= 1'b1;
          r_resume  <= StLoad;
        end
        StWait: begin
          // blk_valid comes up one cycle after entering; ready only counts once it is up.
          if (r_blk_valid && blk_ready) begin
            r_pos   <= '0;
            r_state <= r_resume;
            if (r_last) begin
              r_cnt <= '0;
            end
          end else begin
            r_blk_valid <= 1'b1;
            r_blk_last  <= r_last;
          end
        end
        default: begin
          r_state <= StLoad;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_byte_packer.sv
// tb_sha256_byte_packer
//   Directed bench for sha256_byte_packer. A negedge monitor logs every write and applies it
//   to a 16-word byte-enable buffer model; block contents are checked against SHA-256 padding
//   built byte by byte from the message.
module tb_sha256_byte_packer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [3:0]  wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_ready = 1'b0;

  always #5 CLK = ~CLK;

  sha256_byte_packer #(.LEN_W(13)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .blk_valid(blk_valid),
    .blk_last (blk_last),
    .blk_ready(blk_ready)
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          len;
    bit          gaps;
    int          hold;
    int          nblk;
    logic [31:0] w15;
  } scn_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         wlog[$];
  logic [31:0] bufm[16];
  logic [7:0]  msg[$];
  wr_t         abc_tab[19];
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          rise_cyc = 0;
  int          wr_in_wait = 0;
  int          rdy_in_wait = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: the buffer captures whatever is presented on the write port each cycle.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (wr_en != 4'b0000) begin
      wlog.push_back({wr_en, wr_addr, wr_data});
      for (int l = 0; l < 4; l++) begin
        if (wr_en[l]) bufm[wr_addr][8*l +: 8] = wr_data[8*l +: 8];
      end
      last_wr_cyc = cyc;
      if (blk_valid) wr_in_wait++;
    end
    if (blk_valid && in_ready) rdy_in_wait++;
    if (blk_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = blk_valid;
  end

  task automatic set_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'(8'h61 + (i % 26)));
  endtask

  function automatic logic [7:0] exp_byte(input int g, input int len);
    int          total;
    logic [63:0] bl;
    total = ((len + 9 + 63) / 64) * 64;
    bl    = 64'(len) << 3;
    if (g < len) return msg[g];
    if (g == len) return 8'h80;
    if (g >= total - 8) return bl[8*(total-1-g) +: 8];
    return 8'h00;
  endfunction

  task automatic send_msg(input int len, input bit gaps, input bit mark_last);
    for (int i = 0; i < len; i++) begin
      bit ok;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
      in_byte  = msg[i];
      in_valid = 1'b1;
      in_last  = mark_last && (i == len - 1);
      ok = 1'b0;
      for (int g = 0; g < 2000 && !ok; g++) begin
        @(negedge CLK);
        if (in_ready) begin
          @(posedge CLK);
          #1;
          ok = 1'b1;
        end
      end
      if (!ok) begin
        check($sformatf("byte %0d accepted", i), 64'(ok), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input int nblk, input int hold, input int len);
    for (int k = 0; k < nblk; k++) begin
      int g;
      int drops;
      wr_in_wait  = 0;
      rdy_in_wait = 0;
      g = 0;
      do begin
        @(negedge CLK);
        #1;
        g++;
      end while (!blk_valid && g < 2000);
      if (!blk_valid) begin
        check($sformatf("blk%0d blk_valid arrives", k), 64'(blk_valid), 64'd1);
        return;
      end
      for (int w = 0; w < 16; w++) begin
        logic [31:0] e;
        e = {exp_byte(64*k + 4*w, len), exp_byte(64*k + 4*w + 1, len),
             exp_byte(64*k + 4*w + 2, len), exp_byte(64*k + 4*w + 3, len)};
        check($sformatf("len%0d blk%0d word%0d", len, k, w), 64'(bufm[w]), 64'(e));
      end
      check($sformatf("len%0d blk%0d blk_last", len, k), 64'(blk_last), 64'(k == nblk - 1));
      drops = 0;
      repeat (hold) begin
        @(negedge CLK);
        #1;
        if (!blk_valid) drops++;
      end
      @(posedge CLK);
      #1;
      blk_ready = 1'b1;
      @(negedge CLK);
      #1;
      if (!blk_valid) drops++;
      @(posedge CLK);
      #1;
      blk_ready = 1'b0;
      check($sformatf("len%0d blk%0d valid held", len, k), 64'(drops), 64'd0);
      check($sformatf("len%0d blk%0d no writes in wait", len, k), 64'(wr_in_wait), 64'd0);
      check($sformatf("len%0d blk%0d in_ready low in wait", len, k), 64'(rdy_in_wait), 64'd0);
      check($sformatf("len%0d blk%0d valid drops", len, k), 64'(blk_valid), 64'd0);
    end
  endtask

  task automatic run_scn(input int len, input bit gaps, input int hold, input int nblk);
    set_msg(len);
    wlog.delete();
    for (int w = 0; w < 16; w++) bufm[w] = 32'h0;
    fork
      send_msg(len, gaps, 1'b1);
      consume(nblk, hold, len);
    join
    repeat (3) @(posedge CLK);
    #1;
    check($sformatf("len%0d idle after", len), 64'(blk_valid), 64'd0);
  endtask

  task automatic compare_abc(input string tag);
    check({tag, " write count"}, 64'(wlog.size()), 64'd19);
    for (int i = 0; i < 19 && i < wlog.size(); i++)
      check($sformatf("%s write %0d", tag, i), 64'(wlog[i]), 64'(abc_tab[i]));
    check({tag, " blk_valid one cycle after last write"}, 64'(rise_cyc), 64'(last_wr_cyc + 1));
  endtask

  task automatic hand_checks(input int len);
    case (len)
      3: compare_abc("abc");
      55: begin
        check("len55 write count", 64'(wlog.size()), 64'd58);
        check("len55 pad", 64'(wlog[55]), 64'({4'b0001, 4'd13, 32'h80808080}));
        check("len55 word14", 64'(wlog[56]), 64'({4'hF, 4'd14, 32'h0}));
      end
      56: begin
        check("len56 write count", 64'(wlog.size()), 64'd75);
        check("len56 pad", 64'(wlog[56]), 64'({4'b1000, 4'd14, 32'h80808080}));
        check("len56 zero lanes", 64'(wlog[57]), 64'({4'b0111, 4'd14, 32'h0}));
        check("len56 word15 blk1", 64'(wlog[58]), 64'({4'hF, 4'd15, 32'h0}));
      end
      64: begin
        check("len64 write count", 64'(wlog.size()), 64'd81);
        check("len64 pad", 64'(wlog[64]), 64'({4'b1000, 4'd0, 32'h80808080}));
        check("len64 zero lanes", 64'(wlog[65]), 64'({4'b0111, 4'd0, 32'h0}));
      end
      default: ;
    endcase
  endtask

  initial begin
    scn_t scn[6];
    abc_tab[0] = {4'b1000, 4'd0, 32'h61616161};
    abc_tab[1] = {4'b0100, 4'd0, 32'h62626262};
    abc_tab[2] = {4'b0010, 4'd0, 32'h63636363};
    abc_tab[3] = {4'b0001, 4'd0, 32'h80808080};
    for (int w = 1; w <= 14; w++) abc_tab[w + 3] = {4'hF, 4'(w), 32'h0};
    abc_tab[18] = {4'hF, 4'd15, 32'h00000018};

    scn[0] = '{len: 3,   gaps: 1'b0, hold: 0,  nblk: 1, w15: 32'h018};
    scn[1] = '{len: 55,  gaps: 1'b0, hold: 0,  nblk: 1, w15: 32'h1B8};
    scn[2] = '{len: 56,  gaps: 1'b0, hold: 0,  nblk: 2, w15: 32'h1C0};
    scn[3] = '{len: 64,  gaps: 1'b0, hold: 0,  nblk: 2, w15: 32'h200};
    scn[4] = '{len: 30,  gaps: 1'b1, hold: 10, nblk: 1, w15: 32'h0F0};
    scn[5] = '{len: 100, gaps: 1'b1, hold: 3,  nblk: 2, w15: 32'h320};

    repeat (3) @(posedge CLK);
    #1;
    check("reset wr_en", 64'(wr_en), 64'd0);
    check("reset wr_addr", 64'(wr_addr), 64'd0);
    check("reset wr_data", 64'(wr_data), 64'd0);
    check("reset blk_valid", 64'(blk_valid), 64'd0);
    check("reset blk_last", 64'(blk_last), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      run_scn(scn[i].len, scn[i].gaps, scn[i].hold, scn[i].nblk);
      check($sformatf("len%0d final word15", scn[i].len), 64'(bufm[15]), 64'(scn[i].w15));
      hand_checks(scn[i].len);
    end

    // Reset in the middle of a message, then "abc" must reproduce exactly.
    set_msg(40);
    send_msg(30, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    check("midreset wr_en", 64'(wr_en), 64'd0);
    check("midreset wr_addr", 64'(wr_addr), 64'd0);
    check("midreset wr_data", 64'(wr_data), 64'd0);
    check("midreset blk_valid", 64'(blk_valid), 64'd0);
    check("midreset blk_last", 64'(blk_last), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    run_scn(3, 1'b0, 0, 1);
    compare_abc("abc after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
